// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions for the convolution processor.
//   - Instruction word geometry (INSTR_W, OPCODE_W).
//   - Opcode values used by the fetch/control path.
//   - Program-memory FSM state encoding.
package proc_isa_pkg;

   localparam int INSTR_W  = 16;
   localparam int OPCODE_W = 6;

   localparam logic [OPCODE_W-1:0] FETCH  = 6'd0;
   localparam logic [OPCODE_W-1:0] NOP    = 6'd46;
   localparam logic [OPCODE_W-1:0] JUMPNZ = 6'd47;
   localparam logic [OPCODE_W-1:0] JUMPZ  = 6'd52;
   localparam logic [OPCODE_W-1:0] DECAC  = 6'd59;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: single write port, single read port with a
// registered read (block-RAM friendly). Contents are never reset.
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata holds its value while low
//   raddr  in   read address
//   rdata  out  registered read data (one-cycle latency)
module instr_mem_array
   import proc_isa_pkg::*;
#(
   parameter int W      = 16,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [W-1:0]      wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [W-1:0]      rdata
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory for the convolution processor fetch stage.
// A host streams a program in over a valid/ready port; the core then
// fetches with one-cycle latency. Fetches beyond the loaded length, or
// made while not running, return a NOP word and flag addr_err.
//   clk, rst     clock / asynchronous active-high reset
//   load_start   pulse: begin a program load of load_len words
//   load_len     word count (clamped to DEPTH), sampled with load_start
//   load_data    program word, load_valid qualifies it
//   load_ready   out: a word is accepted this cycle
//   load_done    out: one-cycle pulse after the last word is written
//   rd_en        fetch request for address
//   stall        freeze instr_out / instr_valid / addr_err
//   instr_out    out: fetched instruction
//   instr_valid  out: instr_out holds a fetch result
//   addr_err     out: last fetch was out of range or outside RUN
module instr_mem_loadable
   import proc_isa_pkg::*;
#(
   parameter int INSTR_W    = proc_isa_pkg::INSTR_W,
   parameter int OPCODE_W   = proc_isa_pkg::OPCODE_W,
   parameter int ADDR_W     = 9,
   parameter int DEPTH      = 512,
   parameter int NOP_OPCODE = 46
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_start,
   input  logic [ADDR_W:0]    load_len,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               load_valid,
   output logic               load_ready,
   output logic               load_done,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  address,
   input  logic               stall,
   output logic [INSTR_W-1:0] instr_out,
   output logic               instr_valid,
   output logic               addr_err
);

   localparam logic [OPCODE_W-1:0] NOP_OP   = OPCODE_W'(NOP_OPCODE);
   localparam logic [INSTR_W-1:0]  NOP_WORD = {NOP_OP, {(INSTR_W-OPCODE_W){1'b0}}};
   localparam logic [ADDR_W:0]     DEPTH_L  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]     ONE_L    = (ADDR_W+1)'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                load_done_q, load_done_d;
   logic                instr_valid_q, instr_valid_d;
   logic                addr_err_q, addr_err_d;
   // Selects the NOP word instead of RAM data on the output; this lets
   // the RAM keep its registered read while instr_out still holds.
   logic                nop_sel_q, nop_sel_d;

   logic                we;
   logic                re;
   logic [INSTR_W-1:0]  ram_rdata;
   logic [ADDR_W:0]     clamp_len;
   logic                start_evt;
   logic                word_acc;
   logic                in_range;

   assign clamp_len = (load_len > DEPTH_L) ? DEPTH_L : load_len;
   assign start_evt = load_start && (state_q != LOAD);
   assign word_acc  = (state_q == LOAD) && load_valid;
   assign in_range  = ({1'b0, address} < count_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         len_q         <= '0;
         count_q       <= '0;
         load_done_q   <= 1'b0;
         instr_valid_q <= 1'b0;
         addr_err_q    <= 1'b0;
         nop_sel_q     <= 1'b1;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         len_q         <= len_d;
         count_q       <= count_d;
         load_done_q   <= load_done_d;
         instr_valid_q <= instr_valid_d;
         addr_err_q    <= addr_err_d;
         nop_sel_q     <= nop_sel_d;
      end
   end

   // Load sequencing
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      len_d       = len_q;
      count_d     = count_q;
      load_done_d = 1'b0;
      we          = 1'b0;
      case (state_q)
         IDLE, RUN: begin
            if (load_start) begin
               len_d    = clamp_len;
               wr_ptr_d = '0;
               if (clamp_len == '0) begin
                  // Empty program: nothing to stream, finish immediately.
                  state_d     = RUN;
                  count_d     = '0;
                  load_done_d = 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (load_valid) begin
               we       = 1'b1;
               wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               if ({1'b0, wr_ptr_q} == (len_q - ONE_L)) begin
                  state_d     = RUN;
                  count_d     = len_q;
                  load_done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Fetch response. Load activity wins over any fetch response, and a
   // reload always clears instr_valid even under stall.
   always_comb begin
      instr_valid_d = instr_valid_q;
      addr_err_d    = addr_err_q;
      nop_sel_d     = nop_sel_q;
      re            = 1'b0;
      if (start_evt || word_acc) begin
         instr_valid_d = 1'b0;
      end else if (!stall) begin
         if (rd_en) begin
            instr_valid_d = 1'b1;
            if ((state_q == RUN) && in_range) begin
               re         = 1'b1;
               addr_err_d = 1'b0;
               nop_sel_d  = 1'b0;
            end else begin
               addr_err_d = 1'b1;
               nop_sel_d  = 1'b1;
            end
         end else begin
            instr_valid_d = 1'b0;
         end
      end
   end

   instr_mem_array #(
      .W      (INSTR_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (wr_ptr_q),
      .wdata (load_data),
      .re    (re),
      .raddr (address),
      .rdata (ram_rdata)
   );

   assign load_ready  = (state_q == LOAD);
   assign load_done   = load_done_q;
   assign instr_out   = nop_sel_q ? NOP_WORD : ram_rdata;
   assign instr_valid = instr_valid_q;
   assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
module tb_instr_mem_loadable;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic [9:0]  load_len;
   logic [15:0] load_data;
   logic        load_valid;
   logic        load_ready;
   logic        load_done;
   logic        rd_en;
   logic [8:0]  address;
   logic        stall;
   logic [15:0] instr_out;
   logic        instr_valid;
   logic        addr_err;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   instr_mem_loadable dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .load_len    (load_len),
      .load_data   (load_data),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_done   (load_done),
      .rd_en       (rd_en),
      .address     (address),
      .stall       (stall),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .addr_err    (addr_err)
   );

   typedef struct {
      string       name;
      logic        rd;
      logic [8:0]  addr;
      logic        stl;
      logic [15:0] exp_out;
      logic        exp_valid;
      logic        exp_err;
   } vec_t;

   localparam logic [15:0] NOPW = 16'hB800;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc;
      int dn;
      int cyc;
      logic        lv [6];
      logic [15:0] ld [6];

      vecs[0]  = '{"rd_a2",      1'b1, 9'd2,   1'b0, 16'h1C00, 1'b1, 1'b0};
      vecs[1]  = '{"rd_a0",      1'b1, 9'd0,   1'b0, 16'h0800, 1'b1, 1'b0};
      vecs[2]  = '{"rd_a3_oor",  1'b1, 9'd3,   1'b0, NOPW,     1'b1, 1'b1};
      vecs[3]  = '{"rd_a511_oor",1'b1, 9'd511, 1'b0, NOPW,     1'b1, 1'b1};
      vecs[4]  = '{"rd_a1",      1'b1, 9'd1,   1'b0, 16'h1000, 1'b1, 1'b0};
      vecs[5]  = '{"stall_a2",   1'b1, 9'd2,   1'b1, 16'h1000, 1'b1, 1'b0};
      vecs[6]  = '{"stall_a3",   1'b1, 9'd3,   1'b1, 16'h1000, 1'b1, 1'b0};
      vecs[7]  = '{"idle_rd0",   1'b0, 9'd0,   1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[8]  = '{"rd_a0_b",    1'b1, 9'd0,   1'b0, 16'h0800, 1'b1, 1'b0};
      vecs[9]  = '{"rd_a4_oor",  1'b1, 9'd4,   1'b0, NOPW,     1'b1, 1'b1};
      vecs[10] = '{"stall_nord", 1'b0, 9'd1,   1'b1, NOPW,     1'b1, 1'b1};
      vecs[11] = '{"idle_after", 1'b0, 9'd1,   1'b0, NOPW,     1'b0, 1'b1};

      lv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      ld = '{16'h0000, 16'h0800, 16'h0000, 16'h1000, 16'h1C00, 16'hFFFF};

      rst = 1'b1; load_start = 1'b0; load_len = '0; load_data = '0;
      load_valid = 1'b0; rd_en = 1'b0; address = '0; stall = 1'b0;
      #2;
      check("rst_out",   instr_out,   NOPW);
      check("rst_valid", instr_valid, 0);
      check("rst_err",   addr_err,    0);
      check("rst_ready", load_ready,  0);
      check("rst_done",  load_done,   0);
      tick(); tick();
      rst = 1'b0;

      // Fetch while IDLE
      rd_en = 1'b1; address = 9'd0;
      tick();
      check("idle_out",   instr_out,   NOPW);
      check("idle_err",   addr_err,    1);
      check("idle_valid", instr_valid, 1);
      check("idle_ready", load_ready,  0);
      rd_en = 1'b0;

      // Three-word load with valid gaps
      load_start = 1'b1; load_len = 10'd3;
      tick();
      load_start = 1'b0;
      check("load3_ready", load_ready, 1);
      acc = 0; dn = 0;
      for (int i = 0; i < 6; i++) begin
         load_valid = lv[i];
         load_data  = ld[i];
         if (load_valid && load_ready) acc++;
         tick();
         if (load_done) begin
            dn++;
            check("load3_ready_at_done", load_ready, 0);
         end
      end
      load_valid = 1'b0;
      check("load3_accepted", acc, 3);
      check("load3_done_cnt", dn, 1);

      // Fetch vectors in RUN (count = 3)
      for (int i = 0; i < 12; i++) begin
         rd_en   = vecs[i].rd;
         address = vecs[i].addr;
         stall   = vecs[i].stl;
         tick();
         check({vecs[i].name, "_out"},   instr_out,   vecs[i].exp_out);
         check({vecs[i].name, "_valid"}, instr_valid, vecs[i].exp_valid);
         check({vecs[i].name, "_err"},   addr_err,    vecs[i].exp_err);
      end
      rd_en = 1'b0; stall = 1'b0;

      // Reload from RUN with oversized length (clamped to 512)
      rd_en = 1'b1; address = 9'd0;
      tick();
      check("pre_reload_valid", instr_valid, 1);
      load_start = 1'b1; load_len = 10'd600;
      tick();
      load_start = 1'b0; rd_en = 1'b0;
      check("reload_valid", instr_valid, 0);
      check("reload_ready", load_ready,  1);
      acc = 0; dn = 0; cyc = 0;
      load_len = 10'd5;
      while (dn == 0 && cyc < 800) begin
         load_valid = ((cyc % 7) != 3);
         load_data  = 16'(acc) ^ 16'hA5A5;
         load_start = (cyc == 10);
         if (load_valid && load_ready) acc++;
         tick();
         if (load_done) dn++;
         cyc++;
      end
      load_valid = 1'b0; load_start = 1'b0;
      check("big_accepted", acc, 512);
      check("big_done",     dn,  1);
      check("big_ready_off", load_ready, 0);
      tick();
      check("big_done_pulse", load_done, 0);
      rd_en = 1'b1; address = 9'd511;
      tick();
      check("big_a511_out", instr_out,   16'h01FF ^ 16'hA5A5);
      check("big_a511_err", addr_err,    0);
      check("big_a511_vld", instr_valid, 1);
      address = 9'd0;
      tick();
      check("big_a0_out", instr_out, 16'hA5A5);
      address = 9'd300;
      tick();
      check("big_a300_out", instr_out, 16'd300 ^ 16'hA5A5);
      rd_en = 1'b0;

      // Reset in the middle of a load
      load_start = 1'b1; load_len = 10'd5;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_data = 16'h1111;
      tick();
      load_data = 16'h2222;
      tick();
      load_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midrst_ready", load_ready,  0);
      check("midrst_done",  load_done,   0);
      check("midrst_out",   instr_out,   NOPW);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (load_done) dn++;
      end
      check("midrst_no_done", dn, 0);

      // Zero-length load goes straight to RUN
      load_start = 1'b1; load_len = 10'd0;
      tick();
      load_start = 1'b0;
      check("zero_done",  load_done,  1);
      check("zero_ready", load_ready, 0);
      tick();
      check("zero_done_pulse", load_done, 0);
      for (int a = 0; a < 3; a++) begin
         rd_en = 1'b1; address = 9'(a * 2);
         tick();
         check("zero_fetch_out",   instr_out,   NOPW);
         check("zero_fetch_err",   addr_err,    1);
         check("zero_fetch_valid", instr_valid, 1);
      end
      rd_en = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
